// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise logic unit with STAGES-deep valid/ready pipeline and an
// optional accumulator that can replace operand B.
module logic_unit_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones
);

    localparam logic [2:0] OpAnd  = 3'b000;
    localparam logic [2:0] OpOr   = 3'b001;
    localparam logic [2:0] OpXor  = 3'b010;
    localparam logic [2:0] OpNand = 3'b011;
    localparam logic [2:0] OpNor  = 3'b100;
    localparam logic [2:0] OpXnor = 3'b101;
    localparam logic [2:0] OpPass = 3'b110;
    localparam logic [2:0] OpNot  = 3'b111;

    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  bsel;
    logic [WIDTH-1:0]  r;
    logic              accept;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] zero_q, zero_d;
    logic [STAGES-1:0] ones_q, ones_d;
    logic [STAGES-1:0] stage_ready;
    logic [WIDTH-1:0]  y_q [STAGES];
    logic [WIDTH-1:0]  y_d [STAGES];

    // A stage can take new data if it is empty or its contents move on this
    // cycle; evaluated from the output end back toward the input.
    always_comb begin : ready_chain
        logic rdy;
        rdy         = out_ready;
        stage_ready = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            rdy            = !valid_q[i] || rdy;
            stage_ready[i] = rdy;
        end
    end

    assign in_ready = stage_ready[0];
    assign accept   = in_valid && in_ready;

    always_comb begin
        bsel = acc_mode ? acc_q : b;
        r    = '0;
        unique case (op)
            OpAnd:   r = a & bsel;
            OpOr:    r = a | bsel;
            OpXor:   r = a ^ bsel;
            OpNand:  r = ~(a & bsel);
            OpNor:   r = ~(a | bsel);
            OpXnor:  r = ~(a ^ bsel);
            OpPass:  r = a;
            OpNot:   r = ~a;
            default: r = '0;
        endcase
        if (acc_clear) begin
            r = a;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (accept && (acc_mode || acc_clear)) begin
            acc_d = r;
        end
    end

    // Payload only moves with a valid beat so idle stages keep their last value.
    always_comb begin
        valid_d = valid_q;
        zero_d  = zero_q;
        ones_d  = ones_q;
        for (int i = 0; i < int'(STAGES); i++) begin
            y_d[i] = y_q[i];
        end

        if (stage_ready[0]) begin
            valid_d[0] = accept;
            if (accept) begin
                y_d[0]    = r;
                zero_d[0] = (r == '0);
                ones_d[0] = (r == '1);
            end
        end

        for (int i = 1; i < int'(STAGES); i++) begin
            if (stage_ready[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    y_d[i]    = y_q[i-1];
                    zero_d[i] = zero_q[i-1];
                    ones_d[i] = ones_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '1;
            valid_q <= '0;
            zero_q  <= '0;
            ones_q  <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                y_q[i] <= '0;
            end
        end else begin
            acc_q   <= acc_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            ones_q  <= ones_d;
            for (int i = 0; i < int'(STAGES); i++) begin
                y_q[i] <= y_d[i];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign y         = y_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
    assign ones      = ones_q[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe against a queue-based
// behavioural model (WIDTH=8, STAGES=2).
module tb_logic_unit_pipe;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;
    localparam logic [7:0] TT [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h0F};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         acc_mode = 1'b0;
    logic         acc_clear = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         zero;
    logic         ones;

    int nchecks = 0;
    int nerr = 0;
    int cyc = 0;

    logic [7:0] m_acc = 8'hFF;
    logic [7:0] exp_y [$];
    logic [7:0] obs_y [$];
    logic       obs_z [$];
    logic       obs_o [$];
    int         acc_cyc [$];
    int         obs_cyc [$];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_mode  (acc_mode),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .ones      (ones)
    );

    function automatic logic [7:0] logic_fn(input logic [2:0] o, input logic [7:0] x,
                                            input logic [7:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return ~(x ^ z);
            3'd6: return x;
            default: return ~x;
        endcase
    endfunction

    // One clock: observe transfers mid-cycle, update the model, then step.
    task automatic cycle(output logic accepted);
        logic [7:0] res;
        accepted = 1'b0;
        @(negedge clk);
        if (in_valid && in_ready) begin
            res = acc_clear ? a : logic_fn(op, a, acc_mode ? m_acc : b);
            if (acc_mode || acc_clear) m_acc = res;
            exp_y.push_back(res);
            acc_cyc.push_back(cyc);
            accepted = 1'b1;
        end
        if (out_valid && out_ready) begin
            obs_y.push_back(y);
            obs_z.push_back(zero);
            obs_o.push_back(ones);
            obs_cyc.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        exp_y.delete();
        obs_y.delete();
        obs_z.delete();
        obs_o.delete();
        acc_cyc.delete();
        obs_cyc.delete();
    endtask

    task automatic drain();
        logic acc_f;
        int budget = 100;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (obs_y.size() < exp_y.size() && budget > 0) begin
            cycle(acc_f);
            budget--;
        end
        repeat (S + 1) cycle(acc_f);
        nchecks++;
        if (obs_y.size() != exp_y.size()) begin
            nerr++;
            $display("FAIL drain_count: got %0d results, required %0d", obs_y.size(),
                     exp_y.size());
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        acc_mode  = 1'b0;
        acc_clear = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        m_acc = 8'hFF;
        clear_queues();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nchecks++;
        if ({out_valid, y, zero, ones} !== 11'b0) begin
            nerr++;
            $display("FAIL reset_outputs: got v=%b y=%h z=%b o=%b, required all zero",
                     out_valid, y, zero, ones);
        end
        rst = 1'b0;
        m_acc = 8'hFF;
        clear_queues();
        @(negedge clk);
        nchecks++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_truth_table();
        logic acc_f;
        out_ready = 1'b1;
        acc_mode  = 1'b0;
        acc_clear = 1'b0;
        a = 8'hF0;
        b = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op = 3'(i);
            cycle(acc_f);
            nchecks++;
            if (acc_f !== 1'b1) begin
                nerr++;
                $display("FAIL tt_accept op=%0d: got accepted=%b, required 1", i, acc_f);
            end
        end
        drain();
        for (int i = 0; i < 8 && i < obs_y.size(); i++) begin
            nchecks++;
            if (obs_y[i] !== TT[i] || obs_cyc[i] - acc_cyc[i] != int'(S)) begin
                nerr++;
                $display("FAIL tt_op%0d: got y=%h latency=%0d, required y=%h latency=%0d",
                         i, obs_y[i], obs_cyc[i] - acc_cyc[i], TT[i], S);
            end
        end
        clear_queues();
    endtask

    task automatic test_flags();
        logic acc_f;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'h0F; b = 8'hF0; op = 3'd0;
        cycle(acc_f);
        a = 8'h5A; b = 8'h5A; op = 3'd5;
        cycle(acc_f);
        drain();
        nchecks++;
        if (obs_y.size() < 2 || {obs_y[0], obs_z[0], obs_o[0]} !== {8'h00, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL flags_zero: got %0d results first=%h/%b/%b, required 00/1/0",
                     obs_y.size(), obs_y.size() > 0 ? obs_y[0] : 8'hxx,
                     obs_z.size() > 0 ? obs_z[0] : 1'bx, obs_o.size() > 0 ? obs_o[0] : 1'bx);
        end
        nchecks++;
        if (obs_y.size() < 2 || {obs_y[1], obs_z[1], obs_o[1]} !== {8'hFF, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL flags_ones: got %0d results, second required FF/0/1", obs_y.size());
        end
        clear_queues();
    endtask

    task automatic test_accumulate();
        logic acc_f;
        logic [7:0] av [5] = '{8'hFE, 8'h7F, 8'hF7, 8'hAA, 8'h0F};
        logic [7:0] ev [5] = '{8'hFE, 8'h7E, 8'h76, 8'hAA, 8'h0A};
        do_reset();
        out_ready = 1'b1;
        acc_mode  = 1'b1;
        op = 3'd0;
        b  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            a         = av[i];
            acc_clear = (i == 3);
            cycle(acc_f);
        end
        acc_clear = 1'b0;
        acc_mode  = 1'b0;
        drain();
        for (int i = 0; i < 5; i++) begin
            nchecks++;
            if (i >= obs_y.size() || obs_y[i] !== ev[i]) begin
                nerr++;
                $display("FAIL acc_beat%0d: got %h, required %h", i,
                         i < obs_y.size() ? obs_y[i] : 8'hxx, ev[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_backpressure();
        logic acc_f;
        int k = 0;
        int budget = 50;
        logic [7:0] first;
        acc_mode  = 1'b0;
        acc_clear = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a  = 8'h11 * 8'(k + 1);
            b  = 8'h3C;
            op = 3'(k + 1);
            cycle(acc_f);
            if (acc_f) k++;
        end
        nchecks++;
        if (k != int'(S) || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL bp_fill: got accepts=%0d in_ready=%b, required %0d and 0", k,
                     in_ready, S);
        end
        first = (exp_y.size() > 0) ? exp_y[0] : 8'h00;
        for (int i = 0; i < 3; i++) begin
            cycle(acc_f);
            if (acc_f) k++;
            nchecks++;
            if (out_valid !== 1'b1 || y !== first) begin
                nerr++;
                $display("FAIL bp_stall%0d: got v=%b y=%h, required 1 and %h", i, out_valid,
                         y, first);
            end
        end
        out_ready = 1'b1;
        while (k < 4 && budget > 0) begin
            a  = 8'h11 * 8'(k + 1);
            op = 3'(k + 1);
            cycle(acc_f);
            if (acc_f) k++;
            budget--;
        end
        drain();
        nchecks++;
        if (obs_y.size() != 4) begin
            nerr++;
            $display("FAIL bp_count: got %0d results, required 4", obs_y.size());
        end
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            nchecks++;
            if (obs_y[i] !== exp_y[i]) begin
                nerr++;
                $display("FAIL bp_order%0d: got %h, required %h", i, obs_y[i], exp_y[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_random();
        logic acc_f;
        int k = 0;
        int budget = 20000;
        int bad = 0;
        while (k < 1000 && budget > 0) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom);
            acc_mode  = $urandom_range(0, 1) == 1;
            acc_clear = ($urandom_range(0, 7) == 0);
            cycle(acc_f);
            if (acc_f) k++;
            budget--;
        end
        acc_mode  = 1'b0;
        acc_clear = 1'b0;
        nchecks++;
        if (k != 1000) begin
            nerr++;
            $display("FAIL rand_accepts: got %0d, required 1000", k);
        end
        drain();
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            nchecks++;
            if (obs_y[i] !== exp_y[i] || obs_z[i] !== (exp_y[i] == 8'h00) ||
                obs_o[i] !== (exp_y[i] == 8'hFF)) begin
                nerr++;
                if (bad < 10)
                    $display("FAIL rand_beat%0d: got %h/%b/%b, required %h", i, obs_y[i],
                             obs_z[i], obs_o[i], exp_y[i]);
                bad++;
            end
        end
        clear_queues();
    endtask

    task automatic test_reset_midstream();
        logic acc_f;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc_mode  = 1'b1;
        op        = 3'd0;
        a         = 8'h81;
        cycle(acc_f);
        a = 8'h42;
        cycle(acc_f);
        rst = 1'b1;
        #1;
        nchecks++;
        if (out_valid !== 1'b0 || y !== 8'h00) begin
            nerr++;
            $display("FAIL midrst_outputs: got v=%b y=%h, required 0 and 00", out_valid, y);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_acc = 8'hFF;
        clear_queues();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'h3C;
        cycle(acc_f);
        acc_mode = 1'b0;
        drain();
        nchecks++;
        if (obs_y.size() != 1 || obs_y[0] !== 8'h3C) begin
            nerr++;
            $display("FAIL midrst_acc: got %0d results first=%h, required 1 result 3C",
                     obs_y.size(), obs_y.size() > 0 ? obs_y[0] : 8'hxx);
        end
        clear_queues();
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_flags();
        test_accumulate();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
